// File: rtl/edge_mon_pkg.sv
// Shared constants and helpers for edge_event_monitor.
// Holds the synchronizer depth and filter counter sizing.
package edge_mon_pkg;

  localparam int SYNC_STAGES = 2;

  // Filter run counter width: ceil(log2(len)) + 1.
  function automatic int fc_width(input int filt_len);
    return $clog2(filt_len) + 1;
  endfunction

endpackage

// File: rtl/edge_event_monitor_glitch_filter.sv
// Glitch filter: q follows s2 only after FILT_LEN agreeing samples.
// Ports: clk, reset, s2 in; q, rise, fall, rise_det, fall_det out.
module glitch_filter
  import edge_mon_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic s2,
  output logic q,
  output logic rise,
  output logic fall,
  output logic rise_det,
  output logic fall_det
);

  localparam int FW = fc_width(FILT_LEN);
  localparam logic [FW-1:0] FC_MAX = FW'(FILT_LEN - 1);

  logic [FW-1:0] fc;
  logic          flip;

  // Fires on the edge where q takes the new level; the counters
  // use it so they move together with q.
  assign flip     = (s2 != q) && (fc == FC_MAX);
  assign rise_det = flip & s2;
  assign fall_det = flip & ~s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= 1'b0;
      fc   <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= rise_det;
      fall <= fall_det;
      if (s2 == q) begin
        fc <= '0;
      end else if (flip) begin
        q  <= s2;
        fc <= '0;
      end else begin
        fc <= fc + FW'(1);
      end
    end
  end

endmodule

// File: rtl/edge_event_monitor.sv
// Edge monitor: syncs and filters d, pulses rise/fall, keeps
// saturating edge counts with an atomic snapshot (snap/snap_*).
module edge_event_monitor
  import edge_mon_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  input  logic             clr,
  input  logic             snap,
  output logic             q,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             ovf,
  output logic             snap_valid,
  output logic [CNT_W-1:0] snap_rise,
  output logic [CNT_W-1:0] snap_fall
);

  localparam int CW = CNT_W;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s2;
  logic                   rise_det;
  logic                   fall_det;
  logic                   reload;

  assign s2     = sync[SYNC_STAGES-1];
  assign reload = clr | snap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
    end
  end

  glitch_filter #(
    .FILT_LEN(FILT_LEN)
  ) u_filt (
    .clk     (clk),
    .reset   (reset),
    .s2      (s2),
    .q       (q),
    .rise    (rise),
    .fall    (fall),
    .rise_det(rise_det),
    .fall_det(fall_det)
  );

  // On reload the edge of the same cycle opens the new window,
  // while the snapshot takes the pre-edge counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      ovf        <= 1'b0;
      snap_valid <= 1'b0;
      snap_rise  <= '0;
      snap_fall  <= '0;
    end else begin
      snap_valid <= snap;
      if (snap) begin
        snap_rise <= rise_cnt;
        snap_fall <= fall_cnt;
      end
      if (reload) begin
        rise_cnt <= cnt_t'(rise_det);
        fall_cnt <= cnt_t'(fall_det);
        ovf      <= 1'b0;
      end else begin
        if (rise_det) begin
          if (rise_cnt == CNT_MAX) ovf <= 1'b1;
          else rise_cnt <= rise_cnt + cnt_t'(1);
        end
        if (fall_det) begin
          if (fall_cnt == CNT_MAX) ovf <= 1'b1;
          else fall_cnt <= fall_cnt + cnt_t'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_event_monitor.sv
// Testbench for edge_event_monitor: two instances (CNT_W 8 and 2)
// on shared inputs, checked against a sample-history model.
module tb_edge_event_monitor;

  localparam int FL = 3;

  logic clk = 1'b0;
  logic reset;
  logic d;
  logic clr;
  logic snap;

  logic       q8, r8, f8, o8, v8;
  logic [7:0] rc8, fc8, sr8, sf8;
  logic       q2, r2, f2, o2, v2;
  logic [1:0] rc2, fc2, sr2, sf2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  edge_event_monitor #(.CNT_W(8), .FILT_LEN(FL)) dut8 (
    .clk(clk), .reset(reset), .d(d), .clr(clr), .snap(snap),
    .q(q8), .rise(r8), .fall(f8),
    .rise_cnt(rc8), .fall_cnt(fc8), .ovf(o8),
    .snap_valid(v8), .snap_rise(sr8), .snap_fall(sf8)
  );

  edge_event_monitor #(.CNT_W(2), .FILT_LEN(FL)) dut2 (
    .clk(clk), .reset(reset), .d(d), .clr(clr), .snap(snap),
    .q(q2), .rise(r2), .fall(f2),
    .rise_cnt(rc2), .fall_cnt(fc2), .ovf(o2),
    .snap_valid(v2), .snap_rise(sr2), .snap_fall(sf2)
  );

  // Reference model: q flips once the last FL synchronized samples
  // all disagree with it; s2 seen at edge n is d sampled at n-2.
  bit dh[$];
  int mq = 0, mr = 0, mf = 0, sv = 0;
  int cnt_r[2], cnt_f[2], movf[2], msr[2], msf[2];
  int maxv[2] = '{255, 3};
  bit m_all;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq = 0; mr = 0; mf = 0; sv = 0;
      for (int j = 0; j < 2; j++) begin
        cnt_r[j] = 0; cnt_f[j] = 0; movf[j] = 0;
        msr[j] = 0; msf[j] = 0;
      end
      dh = {};
      repeat (FL + 2) dh.push_front(1'b0);
    end else begin
      m_all = 1'b1;
      for (int i = 1; i <= FL; i++)
        if (int'(dh[i]) == mq) m_all = 1'b0;
      mr = 0; mf = 0;
      if (m_all) begin
        mq = 1 - mq;
        mr = mq;
        mf = 1 - mq;
      end
      dh.push_front(d);
      void'(dh.pop_back());
      sv = int'(snap);
      for (int j = 0; j < 2; j++) begin
        if (snap) begin
          msr[j] = cnt_r[j];
          msf[j] = cnt_f[j];
        end
        if (clr || snap) begin
          cnt_r[j] = mr;
          cnt_f[j] = mf;
          movf[j] = 0;
        end else begin
          if (mr == 1) begin
            if (cnt_r[j] == maxv[j]) movf[j] = 1;
            else cnt_r[j]++;
          end
          if (mf == 1) begin
            if (cnt_f[j] == maxv[j]) movf[j] = 1;
            else cnt_f[j]++;
          end
        end
      end
    end
  end

  function automatic logic [49:0] obs_vec();
    return {q8, r8, f8, rc8, fc8, o8, v8, sr8, sf8,
            q2, r2, f2, rc2, fc2, o2, v2, sr2, sf2};
  endfunction

  function automatic logic [49:0] exp_vec();
    int a0, b0, a1, b1, c0, e0, c1, e1;
    a0 = cnt_r[0]; b0 = cnt_f[0]; a1 = cnt_r[1]; b1 = cnt_f[1];
    c0 = msr[0]; e0 = msf[0]; c1 = msr[1]; e1 = msf[1];
    return {mq[0], mr[0], mf[0], a0[7:0], b0[7:0], movf[0][0],
            sv[0], c0[7:0], e0[7:0],
            mq[0], mr[0], mf[0], a1[1:0], b1[1:0], movf[1][0],
            sv[0], c1[1:0], e1[1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int nr, at;
    d = 1'b1; clr = 1'b0; snap = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (obs_vec() !== 50'd0) begin
      n_err++;
      $display("FAIL reset_state got=%h want=0", obs_vec());
    end
    reset = 1'b0;
    nr = 0; at = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (r8) begin nr++; at = c; end
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL reset_rel c%0d got=%h want=%h",
                 c, obs_vec(), exp_vec());
      end
    end
    n_chk++;
    if (nr != 1 || at != FL + 2 || rc8 !== 8'd1 || q8 !== 1'b1) begin
      n_err++;
      $display("FAIL first_rise n=%0d at=%0d cnt=%0d q=%b want 1/%0d/1/1",
               nr, at, rc8, q8, FL + 2);
    end
  endtask

  task automatic test_glitch();
    int nr, nf;
    d = 1'b0;
    repeat (8) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      nr = 0; nf = 0;
      d = 1'b1;
      for (int c = 0; c < w + 8; c++) begin
        if (c == w) d = 1'b0;
        tick();
        nr += int'(r8); nf += int'(f8);
        n_chk++;
        if (obs_vec() !== exp_vec()) begin
          n_err++;
          $display("FAIL glitch_w%0d c%0d got=%h want=%h",
                   w, c, obs_vec(), exp_vec());
        end
      end
      n_chk++;
      if (nr != (w == 3 ? 1 : 0) || nf != nr || int'(rc8) != nr) begin
        n_err++;
        $display("FAIL glitch_cnt_w%0d rise=%0d fall=%0d cnt=%0d",
                 w, nr, nf, rc8);
      end
    end
  endtask

  task automatic pulses(input int n, input string nm);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < 14; c++) begin
        d = (c < 7);
        tick();
        n_chk++;
        if (obs_vec() !== exp_vec()) begin
          n_err++;
          $display("FAIL %s p%0d c%0d got=%h want=%h",
                   nm, p, c, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_saturation();
    clr = 1'b1; tick(); clr = 1'b0;
    pulses(4, "sat");
    n_chk++;
    if (rc2 !== 2'd3 || fc2 !== 2'd3 || o2 !== 1'b1 ||
        rc8 !== 8'd4 || o8 !== 1'b0) begin
      n_err++;
      $display("FAIL saturate got r=%0d f=%0d o=%b r8=%0d o8=%b want 3 3 1 4 0",
               rc2, fc2, o2, rc8, o8);
    end
    clr = 1'b1; tick(); clr = 1'b0;
    n_chk++;
    if (rc2 !== 2'd0 || fc2 !== 2'd0 || o2 !== 1'b0) begin
      n_err++;
      $display("FAIL sat_clr got r=%0d f=%0d o=%b want 0 0 0",
               rc2, fc2, o2);
    end
  endtask

  task automatic test_snap_collision();
    clr = 1'b1; tick(); clr = 1'b0;
    pulses(5, "pre_snap");
    n_chk++;
    if (rc8 !== 8'd5) begin
      n_err++;
      $display("FAIL pre_snap_cnt got=%0d want=5", rc8);
    end
    d = 1'b1;
    repeat (4) tick();
    snap = 1'b1; tick(); snap = 1'b0;
    n_chk++;
    if (r8 !== 1'b1 || sr8 !== 8'd5 || rc8 !== 8'd1 || v8 !== 1'b1) begin
      n_err++;
      $display("FAIL snap_coll got r=%b s=%0d c=%0d v=%b want 1 5 1 1",
               r8, sr8, rc8, v8);
    end
    n_chk++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL snap_coll_mdl got=%h want=%h", obs_vec(), exp_vec());
    end
    tick();
    n_chk++;
    if (v8 !== 1'b0) begin
      n_err++;
      $display("FAIL snap_valid_len got=%b want=0", v8);
    end
  endtask

  task automatic test_reset_mid();
    int nr;
    d = 1'b0;
    repeat (8) tick();
    d = 1'b1;
    repeat (4) tick();
    #2;
    reset = 1'b1;
    d = 1'b0;
    #1;
    n_chk++;
    if (obs_vec() !== 50'd0) begin
      n_err++;
      $display("FAIL async_reset got=%h want=0", obs_vec());
    end
    @(negedge clk);
    reset = 1'b0;
    nr = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      nr += int'(r8) + int'(f8);
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL rst_mid c%0d got=%h want=%h",
                 c, obs_vec(), exp_vec());
      end
    end
    n_chk++;
    if (nr != 0) begin
      n_err++;
      $display("FAIL rst_mid_edges got=%0d want=0", nr);
    end
  endtask

  task automatic test_back_to_back();
    clr = 1'b1; tick(); clr = 1'b0;
    d = 1'b1;
    repeat (4) tick();
    snap = 1'b1; tick();
    n_chk++;
    if (v8 !== 1'b1 || sr8 !== 8'd0 || rc8 !== 8'd1) begin
      n_err++;
      $display("FAIL b2b_first got v=%b s=%0d c=%0d want 1 0 1",
               v8, sr8, rc8);
    end
    tick(); snap = 1'b0;
    n_chk++;
    if (v8 !== 1'b1 || sr8 !== 8'd1 || rc8 !== 8'd0) begin
      n_err++;
      $display("FAIL b2b_second got v=%b s=%0d c=%0d want 1 1 0",
               v8, sr8, rc8);
    end
    tick();
    n_chk++;
    if (v8 !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL b2b_end got v=%b vec=%h want 0 %h",
               v8, obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) d = ~d;
      snap = ($urandom_range(0, 15) == 0);
      clr  = ($urandom_range(0, 31) == 0);
      tick();
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random c%0d got=%h want=%h",
                 c, obs_vec(), exp_vec());
      end
    end
    snap = 1'b0;
    clr  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_saturation();
    test_snap_collision();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
